// File: rtl/music_sequencer_if.sv
// +--------------------------------------------------------------------+
// | music_sequencer_if                                                 |
// | Control and status bundle for the music sequencer.                 |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface music_sequencer_if;
  logic       start;
  logic       stop;
  logic       loop;
  logic       speaker;
  logic       playing;
  logic       done;
  logic [2:0] note_idx;

  modport master (output start, stop, loop,
                  input  speaker, playing, done, note_idx);
  modport slave  (input  start, stop, loop,
                  output speaker, playing, done, note_idx);
endinterface

`default_nettype wire

// File: rtl/music_sequencer.sv
// +--------------------------------------------------------------------+
// | music_sequencer                                                    |
// | Plays a fixed 8-note song from ROM as a square wave on speaker,    |
// | with a silent gap after every note, optional looping and abort.    |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module music_sequencer #(
  parameter int TICK_CYC = 25000000,
  parameter int GAP_CYC  = 2500000,
  parameter int H1       = 191113,
  parameter int H2       = 170265,
  parameter int H3       = 151685,
  parameter int H4       = 143172,
  parameter int H5       = 127551,
  parameter int H6       = 113636,
  parameter int H7       = 101238
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  music_sequencer_if.slave   bus
);

  // The tick counter is shared between PLAY (beat timing) and GAP.
  localparam int CNT_MAX = (TICK_CYC > GAP_CYC) ? TICK_CYC : GAP_CYC;
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] c_tick_last = CNT_W'(TICK_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_note_idx;
  logic [17:0]      r_half;
  logic             r_rest;
  logic [2:0]       r_dur;
  logic [17:0]      r_tone;
  logic [CNT_W-1:0] r_tick;
  logic [2:0]       r_beat;
  logic             r_speaker;
  logic             r_playing;
  logic             r_done;

  logic [2:0]       w_rom_code;
  logic [2:0]       w_rom_dur;
  logic [17:0]      w_rom_half;
  logic             w_tick_wrap;
  logic             w_last_beat;
  logic             w_gap_end;

  // Song ROM and tone-code to half-period lookup.
  always_comb begin
    w_rom_code = 3'd0;
    w_rom_dur  = 3'd1;
    case (r_note_idx)
      3'd0: begin w_rom_code = 3'd1; w_rom_dur = 3'd1; end
      3'd1: begin w_rom_code = 3'd1; w_rom_dur = 3'd1; end
      3'd2: begin w_rom_code = 3'd5; w_rom_dur = 3'd1; end
      3'd3: begin w_rom_code = 3'd5; w_rom_dur = 3'd1; end
      3'd4: begin w_rom_code = 3'd6; w_rom_dur = 3'd1; end
      3'd5: begin w_rom_code = 3'd6; w_rom_dur = 3'd1; end
      3'd6: begin w_rom_code = 3'd5; w_rom_dur = 3'd2; end
      default: begin w_rom_code = 3'd0; w_rom_dur = 3'd1; end
    endcase
    case (w_rom_code)
      3'd1:    w_rom_half = 18'(H1);
      3'd2:    w_rom_half = 18'(H2);
      3'd3:    w_rom_half = 18'(H3);
      3'd4:    w_rom_half = 18'(H4);
      3'd5:    w_rom_half = 18'(H5);
      3'd6:    w_rom_half = 18'(H6);
      3'd7:    w_rom_half = 18'(H7);
      default: w_rom_half = 18'd2;  // rest: value unused, speaker is masked
    endcase
  end

  // Next-state logic; stop overrides everything, including start in IDLE.
  always_comb begin
    w_next      = r_state;
    w_tick_wrap = (r_tick == c_tick_last);
    w_last_beat = w_tick_wrap && ((r_beat + 3'd1) == r_dur);
    w_gap_end   = (r_tick == c_gap_last);
    case (r_state)
      S_IDLE: if (bus.start) w_next = S_LOAD;
      S_LOAD: w_next = S_PLAY;
      S_PLAY: if (w_last_beat) w_next = S_GAP;
      S_GAP: begin
        if (w_gap_end) begin
          if ((r_note_idx == 3'd7) && !bus.loop) w_next = S_IDLE;
          else                                   w_next = S_LOAD;
        end
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.stop) w_next = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Note sequencing, tone/beat/gap counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note_idx <= 3'd0;
      r_half     <= 18'd0;
      r_rest     <= 1'b0;
      r_dur      <= 3'd0;
      r_tone     <= 18'd0;
      r_tick     <= '0;
      r_beat     <= 3'd0;
      r_speaker  <= 1'b0;
      r_playing  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_playing <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_speaker <= 1'b0;
          if (w_next == S_LOAD) r_note_idx <= 3'd0;
        end
        S_LOAD: begin
          r_half    <= w_rom_half;
          r_rest    <= (w_rom_code == 3'd0);
          r_dur     <= w_rom_dur;
          r_tone    <= 18'd0;
          r_tick    <= '0;
          r_beat    <= 3'd0;
          r_speaker <= 1'b0;
        end
        S_PLAY: begin
          if (w_tick_wrap) begin
            r_tick <= '0;
            r_beat <= r_beat + 3'd1;
          end else begin
            r_tick <= r_tick + CNT_W'(1);
          end
          if (r_tone == (r_half - 18'd1)) begin
            r_tone <= 18'd0;
            if (!r_rest) r_speaker <= ~r_speaker;
          end else begin
            r_tone <= r_tone + 18'd1;
          end
          // Leaving PLAY: silence and restart the counter for the gap.
          if (w_next == S_GAP) begin
            r_speaker <= 1'b0;
            r_tick    <= '0;
          end
        end
        S_GAP: begin
          r_speaker <= 1'b0;
          r_tick    <= r_tick + CNT_W'(1);
          if (w_gap_end) begin
            r_tick <= '0;
            if (r_note_idx == 3'd7) begin
              if (bus.loop) r_note_idx <= 3'd0;
              else          r_done     <= 1'b1;
            end else begin
              r_note_idx <= r_note_idx + 3'd1;
            end
          end
        end
        default: r_speaker <= 1'b0;
      endcase
      if (bus.stop) begin
        r_speaker  <= 1'b0;
        r_note_idx <= 3'd0;
        r_done     <= 1'b0;
      end
    end
  end

  assign bus.speaker  = r_speaker;
  assign bus.playing  = r_playing;
  assign bus.done     = r_done;
  assign bus.note_idx = r_note_idx;

endmodule

`default_nettype wire

// File: doc/music_sequencer.md
MUSIC_SEQUENCER -- requirements
Module: music_sequencer

Interface
REQ-001 Parameter TICK_CYC, 25000000, clock cycles per beat (≥2).
REQ-002 Parameter GAP_CYC, 2500000, silent clock cycles after every note (≥1).
REQ-003 Parameters H1..H7, 191113/170265/151685/143172/127551/113636/101238, half-period in clock cycles for tone codes 1..7 (C4..B4 at 100 MHz); each value SHALL be ≥2 and <2^18.
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 start  input  1  level-sampled play request, acted on only in IDLE.
REQ-007 stop  input  1  abort request, acted on in any state.
REQ-008 loop  input  1  sampled at end of last note; 1 = restart at note 0.
REQ-009 speaker  output  1  registered square-wave audio to the speaker driver.
REQ-010 playing  output  1  high whenever state ≠ IDLE.
REQ-011 note_idx  output  3  index of current song entry.
REQ-012 done  output  1  one-cycle pulse on normal song completion.

Function
REQ-013 The module SHALL hold a fixed 8-entry song ROM of (tone code 0..7, duration 1..4 beats): 0:(1,1) 1:(1,1) 2:(5,1) 3:(5,1) 4:(6,1) 5:(6,1) 6:(5,2) 7:(0,1); tone code 0 = rest.
REQ-014 The FSM SHALL have exactly the states IDLE, LOAD, PLAY and GAP.
REQ-015 IDLE: speaker=0; start=1 and stop=0 SHALL move to LOAD with note_idx=0.
REQ-016 LOAD: one cycle; latches the half-period, the rest flag and the duration of entry note_idx; clears the tone, tick and beat counters; speaker=0; then PLAY.
REQ-017 PLAY tone: the 18-bit tone counter counts 0..H-1; at H-1 it SHALL wrap to 0 and toggle speaker, giving a first rising edge H cycles after PLAY entry and period 2H.
REQ-018 PLAY rest (code 0): speaker SHALL stay 0 for the whole note.
REQ-019 PLAY timing: the tick counter counts 0..TICK_CYC-1 and increments the beat counter on wrap; on the wrap that makes beats = duration, the FSM SHALL enter GAP, so PLAY lasts exactly duration×TICK_CYC cycles.
REQ-020 GAP: speaker=0 for exactly GAP_CYC cycles; at its end:
- if note_idx<7: note_idx+1 and go to LOAD;
- if note_idx=7 and loop=1: note_idx=0 and go to LOAD, no done;
- if note_idx=7 and loop=0: go to IDLE with done=1 for that single first IDLE cycle.
REQ-021 stop=1 in any state SHALL force IDLE at the next edge with speaker=0 and note_idx=0, and SHALL NOT pulse done; stop has priority over start.
REQ-022 start while playing=1 SHALL be ignored; start held high in IDLE restarts the song on the next edge, including the cycle right after done.
REQ-023 speaker, done and playing SHALL be driven from registers, with no combinational path from inputs.
REQ-024 Each note SHALL occupy exactly 1 + duration×TICK_CYC + GAP_CYC cycles.

Reset
REQ-025 rst_n=0 SHALL immediately set state=IDLE, speaker=0, playing=0, done=0, note_idx=0 and clear all counters, including in mid-note.
REQ-026 After rst_n deasserts, no playback SHALL begin until start is sampled high.

Verification (TICK_CYC=20, GAP_CYC=4, H1=7, H5=3, H6=2)
REQ-027 Reset mid-PLAY at note 3:
- stimulus: assert rst_n=0;
- response: speaker=0, playing=0 and note_idx=0 with no clock edge; held idle after release.
REQ-028 Start pulse at edge E0, loop=0:
- LOAD in cycle E0..E0+1, then speaker rises at E0+8 and toggles every 7 cycles for 20 cycles;
- done high exactly in cycle E0+220..E0+221, playing low from E0+220.
REQ-029 Note 6 (code 5, 2 beats):
- PLAY lasts 40 cycles with a speaker period of 6 cycles;
- note 7 (rest): speaker=0 for all 25 cycles.
REQ-030 loop=1 at end of note 7:
- note_idx returns to 0 with no done pulse;
- the second pass is cycle-identical to the first.
REQ-031 stop=1 for one cycle during note 2 PLAY, with start=1 in the same cycle:
- next cycle IDLE, speaker=0, note_idx=0, done=0;
- start held high afterwards restarts the song one cycle later.
